// File: rtl/pipeline_ex_muldiv_if.sv
// Handshake bundle between the EX stage and the M-extension unit.
// master = issuing EX stage / consumer, slave = the mul/div unit.
interface pipeline_ex_muldiv_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned REG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic             in_is_word;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [REG_W-1:0] in_dst_reg;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_res;
  logic [REG_W-1:0] out_dst_reg;

  modport master (
    output in_valid, in_op, in_is_word, in_rs1, in_rs2, in_dst_reg, out_ready,
    input  in_ready, out_valid, out_res, out_dst_reg
  );

  modport slave (
    input  in_valid, in_op, in_is_word, in_rs1, in_rs2, in_dst_reg, out_ready,
    output in_ready, out_valid, out_res, out_dst_reg
  );
endinterface

// File: rtl/pipeline_ex_muldiv.sv
// Iterative RISC-V M-extension execute unit: radix-2 shift-add multiplier and
// restoring divider, one bit per cycle, valid/ready on both sides.
module pipeline_ex_muldiv #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned REG_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipeline_ex_muldiv_if.slave  bus,
  output logic                 busy
);
  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = XLEN'($signed(32'h8000_0000));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic              word_q, neg_q, negrem_q;
  logic [2*XLEN-1:0] opa, acc;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   res_q;
  logic [REG_W-1:0]  dst_q;

  // Accept-time operand conditioning
  logic            accept, is_div, is_mulh, word, sgn_a, sgn_b;
  logic            neg_a, neg_b, div_zero, div_ovf, fast;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, fast_res;

  assign accept  = bus.in_valid && (state == IDLE) && !flush;
  assign is_div  = bus.in_op[2];
  assign is_mulh = !bus.in_op[2] && (bus.in_op[1:0] != 2'b00);
  assign word    = (XLEN == 64) && bus.in_is_word && !is_mulh;
  assign sgn_a   = is_div ? !bus.in_op[0]
                          : (bus.in_op[1:0] == 2'b01) || (bus.in_op[1:0] == 2'b10);
  assign sgn_b   = is_div ? !bus.in_op[0] : (bus.in_op[1:0] == 2'b01);

  assign a_ext = !word ? bus.in_rs1 :
                 sgn_a ? XLEN'($signed(bus.in_rs1[31:0])) : XLEN'(bus.in_rs1[31:0]);
  assign b_ext = !word ? bus.in_rs2 :
                 sgn_b ? XLEN'($signed(bus.in_rs2[31:0])) : XLEN'(bus.in_rs2[31:0]);

  assign neg_a = sgn_a && a_ext[XLEN-1];
  assign neg_b = sgn_b && b_ext[XLEN-1];
  assign mag_a = neg_a ? -a_ext : a_ext;
  assign mag_b = neg_b ? -b_ext : b_ext;

  assign div_zero = (b_ext == '0);
  assign div_ovf  = sgn_a && (b_ext == '1) && (a_ext == (word ? MIN_W : MIN_X));
  assign fast     = is_div && (div_zero || div_ovf);

  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = bus.in_op[1] ? (word ? XLEN'($signed(a_ext[31:0])) : a_ext) : '1;
    else if (!bus.in_op[1])
      fast_res = a_ext;
  end

  // One iteration of either datapath, plus final sign correction
  logic [2*XLEN-1:0] prod_nxt, prod_fin;
  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, rem_fin, quo_fin, raw, run_res;

  assign prod_nxt = opb[0] ? acc + opa : acc;
  assign shifted  = {acc[XLEN-1:0], opa[XLEN-1]};
  assign diff     = shifted - {1'b0, opb};
  assign rem_nxt  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nxt  = {opa[XLEN-2:0], ~diff[XLEN]};

  assign prod_fin = neg_q    ? -prod_nxt : prod_nxt;
  assign quo_fin  = neg_q    ? -quo_nxt  : quo_nxt;
  assign rem_fin  = negrem_q ? -rem_nxt  : rem_nxt;

  always_comb begin
    raw = '0;
    if (op_q[2])
      raw = op_q[1] ? rem_fin : quo_fin;
    else if (op_q[1:0] == 2'b00)
      raw = prod_fin[XLEN-1:0];
    else
      raw = prod_fin[2*XLEN-1:XLEN];
  end

  assign run_res = word_q ? XLEN'($signed(raw[31:0])) : raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (accept) state_next = fast ? DONE : RUN;
      end
      RUN:  if (count == CW'(1)) state_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      negrem_q <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      res_q    <= '0;
      dst_q    <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (accept) begin
      op_q     <= bus.in_op;
      word_q   <= word;
      neg_q    <= neg_a ^ neg_b;
      negrem_q <= neg_a;
      dst_q    <= bus.in_dst_reg;
      // Word dividends are pre-aligned so the MSB-first loop ends after 32 steps
      opa      <= {{XLEN{1'b0}}, (is_div && word) ? mag_a << (XLEN - 32) : mag_a};
      opb      <= mag_b;
      acc      <= '0;
      count    <= word ? CW'(32) : CW'(XLEN);
      if (fast) res_q <= fast_res;
    end else if (state == RUN) begin
      count <= count - CW'(1);
      if (op_q[2]) begin
        opa <= {{XLEN{1'b0}}, quo_nxt};
        acc <= {{XLEN{1'b0}}, rem_nxt};
      end else begin
        acc <= prod_nxt;
        opa <= opa << 1;
        opb <= opb >> 1;
      end
      if (count == CW'(1)) res_q <= run_res;
    end
  end

  assign bus.out_res     = res_q;
  assign bus.out_dst_reg = dst_q;
endmodule

// File: tb/tb_pipeline_ex_muldiv.sv
// Scoreboard bench for pipeline_ex_muldiv at XLEN=64. Latency is counted in
// clock edges including the accept edge (fast paths = 1, 64-bit ops = 65).
module tb_pipeline_ex_muldiv;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned REG_W = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  pipeline_ex_muldiv_if #(.XLEN(XLEN), .REG_W(REG_W)) bus ();

  pipeline_ex_muldiv #(.XLEN(XLEN), .REG_W(REG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  dst;
    int          lat;
  } exp_t;

  exp_t expq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: native wide arithmetic, RISC-V corner cases handled explicitly
  function automatic void ref_model(input logic [2:0] op, input bit w_in,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] res, output int lat);
    logic [127:0] pr, ua, ub, sa, sbx;
    logic [63:0]  x, y, q, r;
    bit           w, sgn, ovf;
    w   = w_in && !(op inside {3'd1, 3'd2, 3'd3});
    ua  = {64'd0, a};
    ub  = {64'd0, b};
    sa  = {{64{a[63]}}, a};
    sbx = {{64{b[63]}}, b};
    lat = w ? 33 : 65;
    res = '0;
    if (!op[2]) begin
      case (op[1:0])
        2'd0:    pr = ua * ub;
        2'd1:    pr = sa * sbx;
        2'd2:    pr = sa * ub;
        default: pr = ua * ub;
      endcase
      if (op[1:0] == 2'd0) res = w ? sx32(pr[31:0]) : pr[63:0];
      else                 res = pr[127:64];
    end else begin
      sgn = !op[0];
      x   = w ? (sgn ? sx32(a[31:0]) : {32'd0, a[31:0]}) : a;
      y   = w ? (sgn ? sx32(b[31:0]) : {32'd0, b[31:0]}) : b;
      ovf = sgn && (y == 64'hFFFF_FFFF_FFFF_FFFF) &&
            (x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      if (y == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; r = x; lat = 1;
      end else if (ovf) begin
        q = x; r = 64'd0; lat = 1;
      end else if (sgn) begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
      end else begin
        q = x / y;
        r = x % y;
      end
      res = op[1] ? r : q;
      if (w) res = sx32(res[31:0]);
    end
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0000_0000_8000_0000;
      4:       return 64'($urandom_range(0, 40));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Pushes the expectation, offers the op, waits (bounded) for the result
  task automatic issue(input logic [2:0] op, input bit w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res,
                       input int exp_lat, input bit ack,
                       output logic [63:0] res, output logic [4:0] dsto, output int lat);
    logic [4:0] dst;
    int         guard;
    dst = 5'($urandom_range(1, 31));
    expq.push_back('{exp_res, dst, exp_lat});
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_is_word = w;
    bus.in_rs1     = a;
    bus.in_rs2     = b;
    bus.in_dst_reg = dst;
    bus.out_ready  = ack;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
    res  = bus.out_res;
    dsto = bus.out_dst_reg;
    if (ack) tick();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_res !== 64'd0 || bus.out_dst_reg !== 5'd0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b res=%h dst=%0d, want all zero",
               bus.out_valid, busy, bus.out_res, bus.out_dst_reg);
    end
    #9 reset = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [3] = '{3'd0, 3'd3, 3'd2};
    logic [63:0] as  [3] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] bs  [3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
    logic [63:0] xs  [3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] res;
    logic [4:0]  dsto;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 1'b0, as[i], bs[i], xs[i], 65, 1'b1, res, dsto, lat);
      e = expq.pop_front();
      checks++;
      if (res !== e.res) begin errors++; $display("FAIL mul[%0d] res: got %h want %h", i, res, e.res); end
      checks++;
      if (dsto !== e.dst) begin errors++; $display("FAIL mul[%0d] dst: got %0d want %0d", i, dsto, e.dst); end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [63:0] as  [4] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100};
    logic [63:0] bs  [4] = '{64'd2, 64'd2, 64'd7, 64'd7};
    logic [63:0] xs  [4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd14, 64'd2};
    logic [63:0] res;
    logic [4:0]  dsto;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 1'b0, as[i], bs[i], xs[i], 65, 1'b1, res, dsto, lat);
      e = expq.pop_front();
      checks++;
      if (res !== e.res) begin errors++; $display("FAIL div[%0d] res: got %h want %h", i, res, e.res); end
      checks++;
      if (dsto !== e.dst) begin errors++; $display("FAIL div[%0d] dst: got %0d want %0d", i, dsto, e.dst); end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  // Fast paths and word forms
  task automatic test_div_special();
    logic [2:0]  ops [6] = '{3'd4, 3'd6, 3'd6, 3'd4, 3'd5, 3'd0};
    bit          ws  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] as  [6] = '{64'h0000_0000_8000_0000, 64'h1234, 64'h0000_0000_8000_0001,
                             64'd55, 64'd100, 64'h0000_0000_7FFF_FFFF};
    logic [63:0] bs  [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0, 64'd7, 64'd2};
    logic [63:0] xs  [6] = '{64'hFFFF_FFFF_8000_0000, 64'h1234, 64'hFFFF_FFFF_8000_0001,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE};
    int          ls  [6] = '{1, 1, 1, 1, 33, 33};
    logic [63:0] res;
    logic [4:0]  dsto;
    int          lat;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], ws[i], as[i], bs[i], xs[i], ls[i], 1'b1, res, dsto, lat);
      e = expq.pop_front();
      checks++;
      if (res !== e.res) begin errors++; $display("FAIL special[%0d] res: got %h want %h", i, res, e.res); end
      checks++;
      if (dsto !== e.dst) begin errors++; $display("FAIL special[%0d] dst: got %0d want %0d", i, dsto, e.dst); end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL special[%0d] latency: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] res;
    logic [4:0]  dsto;
    int          lat;
    exp_t        e;
    issue(3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 65, 1'b0, res, dsto, lat);
    e = expq.pop_front();
    checks++;
    if (res !== e.res || lat != e.lat) begin
      errors++;
      $display("FAIL bp_first: got res=%h lat=%0d want res=%h lat=%0d", res, lat, e.res, e.lat);
    end
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd5;
    bus.in_rs1   = 64'd999;
    bus.in_rs2   = 64'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_res !== e.res || bus.out_dst_reg !== e.dst || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b res=%h dst=%0d in_ready=%b want 1 %h %0d 0",
                 i, bus.out_valid, bus.out_res, bus.out_dst_reg, bus.in_ready, e.res, e.dst);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    issue(3'd5, 1'b0, 64'd9, 64'd3, 64'd3, 65, 1'b1, res, dsto, lat);
    e = expq.pop_front();
    checks++;
    if (res !== e.res || dsto !== e.dst || lat != e.lat) begin
      errors++;
      $display("FAIL bp_next: got res=%h dst=%0d lat=%0d want %h %0d %0d", res, dsto, lat, e.res, e.dst, e.lat);
    end
  endtask

  task automatic test_flush();
    bit seen;
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_op      = 3'd4;
    bus.in_is_word = 1'b0;
    bus.in_rs1     = 64'hFFFF_FFFF_FFFF_FF9C;
    bus.in_rs2     = 64'd3;
    bus.in_dst_reg = 5'd9;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL flush_accept: busy=%b want 1", busy); end
    repeat (19) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: valid=%b busy=%b in_ready=%b want 0 0 1", bus.out_valid, busy, bus.in_ready);
    end
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_no_result: out_valid seen=1 want 0"); end
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_beats_accept: busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    logic [4:0]  dsto;
    int          lat;
    exp_t        e;
    bus.in_valid   = 1'b1;
    bus.in_op      = 3'd0;
    bus.in_is_word = 1'b0;
    bus.in_rs1     = 64'd1000;
    bus.in_rs2     = 64'd1000;
    bus.in_dst_reg = 5'd7;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_res !== 64'd0 || bus.out_dst_reg !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b res=%h dst=%0d want all zero",
               bus.out_valid, busy, bus.out_res, bus.out_dst_reg);
    end
    #2 reset = 1'b1;
    tick();
    issue(3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 65, 1'b1, res, dsto, lat);
    e = expq.pop_front();
    checks++;
    if (res !== e.res || dsto !== e.dst || lat != e.lat) begin
      errors++;
      $display("FAIL after_reset_mul: got res=%h dst=%0d lat=%0d want %h %0d %0d", res, dsto, lat, e.res, e.dst, e.lat);
    end
  endtask

  // Random ops issued back to back
  task automatic test_random();
    logic [2:0]  op;
    bit          w;
    logic [63:0] a, b, xr, res;
    logic [4:0]  dsto;
    int          xl, lat;
    exp_t        e;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = pick();
      b  = pick();
      ref_model(op, w, a, b, xr, xl);
      issue(op, w, a, b, xr, xl, 1'b1, res, dsto, lat);
      e = expq.pop_front();
      checks++;
      if (res !== e.res) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d w=%0b a=%h b=%h res: got %h want %h", i, op, w, a, b, res, e.res);
      end
      checks++;
      if (dsto !== e.dst) begin errors++; $display("FAIL rand[%0d] dst: got %0d want %0d", i, dsto, e.dst); end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL rand[%0d] op=%0d latency: got %0d want %0d", i, op, lat, e.lat); end
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_op      = 3'd0;
    bus.in_is_word = 1'b0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_dst_reg = '0;
    bus.out_ready  = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipeline_ex_muldiv.md
Name: pipeline_ex_muldiv

Overview:
- Multi-cycle RISC-V M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus the word forms MULW/DIVW/DIVUW/REMW/REMUW.
- Sits beside the single-cycle ALU in the EX stage. The EX stage routes M-extension ops here and stalls on in_ready/out_valid.
- Iterative: radix-2 shift-add multiplier and restoring shift-subtract divider, one bit per cycle, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- REG_W, 5, destination register tag width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of any in-flight op.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept.
- in_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_is_word  in  1  32-bit word form; ignored when XLEN=32 and for MULH/MULHSU/MULHU.
- in_rs1  in  XLEN  operand 1.
- in_rs2  in  XLEN  operand 2.
- in_dst_reg  in  REG_W  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_res  out  XLEN  result.
- out_dst_reg  out  REG_W  tag of the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, out_valid=0, out_res=0, out_dst_reg=0, busy=0, counter=0. in_ready=1 once reset is released.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept happens on an edge where in_valid & in_ready & !flush.
  - On accept, latch op, word flag and dst_reg, and condition the operands:
    - Word forms take bits [31:0] and extend them: sign-extend for signed ops, zero-extend for unsigned ops.
    - Signed operands are converted to magnitude plus a sign flag.
  - Set N=32 for word forms, else N=XLEN. Go to RUN with counter=N.
- Divide fast paths (decided at accept; go straight to DONE, total latency 1):
  - Divisor zero: quotient = all ones; remainder = dividend (word forms: sign-extended [31:0]).
  - Signed overflow (dividend = most-negative, divisor = -1, in the operating width): quotient = dividend; remainder = 0.
- RUN:
  - Each edge performs one iteration and decrements counter.
  - The edge at which counter reaches 0 applies sign correction (negate product or quotient if the operand signs differ; the remainder takes the dividend's sign).
  - Result selection:
    - MUL/MULW: low half of the product.
    - MULH*: high XLEN bits of the 2*XLEN product.
    - Word results: sign-extend bit 31 to XLEN.
  - On that edge, register out_res and go to DONE.
  - Latency from accept edge to out_valid=1 is N+1 cycles: 65 for 64-bit ops, 33 for word ops at XLEN=64.
- DONE:
  - out_valid=1. out_res and out_dst_reg stay stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE, out_valid=0.
  - No accept in the same cycle, so there is a one-cycle bubble between ops.
- flush:
  - In any state: next edge goes to IDLE, out_valid=0, no result delivered.
  - flush wins over a simultaneous accept or out handshake.
- Async reset mid-RUN: immediate return to reset values; the partial result is discarded.
- in_ready=0 in RUN and DONE. Input ports are don't-care there.

Test Plan:
- MUL, rs1=7, rs2=-3 (XLEN=64) -> out_res=0xFFFFFFFFFFFFFFEB, out_valid exactly 65 cycles after the accept edge, dst tag preserved.
- MULHU, rs1=rs2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
- MULHSU, rs1=-1, rs2=2 -> 0xFFFFFFFFFFFFFFFF.
- DIV rs1=-7, rs2=2 -> -3. REM with the same operands -> -1. DIVU rs1=100, rs2=7 -> 14. REMU with the same operands -> 2.
- DIVW, rs1=0x0000000080000000, rs2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF80000000, latency 1.
- REM, rs2=0, rs1=0x1234 -> 0x1234, latency 1.
- REMW, rs2=0, rs1=0x00000000_80000001 -> 0xFFFFFFFF80000001.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_res stable, in_ready=0. Release -> IDLE next cycle, then a new accept.
- flush at cycle 20 of a 64-bit DIV -> IDLE next edge, no out_valid pulse.
- Async reset asserted mid-RUN -> outputs zero immediately. A subsequent MUL 3*5 returns 15.
